// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: round-robin arbiter between the CPU and a secondary (DMA)
// master for the shared memory/IO bus. The winner's request is latched onto
// the bus, the arbiter waits for bus_ready, returns the read data and
// acknowledges the owner with a one-cycle ready pulse.
//
// Optional feature: define MIO_ARB_TIMEOUT_EN to abort a transfer that has
// waited TIMEOUT_CYCLES cycles without bus_ready. The aborted transfer returns
// zero data and sets the sticky timeout_err flag.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request (held until cpu_ready)
//   cpu_ready, cpu_rdata            CPU completion pulse and read data
//   dma_req/we/addr/wdata           DMA request (held until dma_ready)
//   dma_ready, dma_rdata            DMA completion pulse and read data
//   bus_req/we/addr/wdata           registered bus request
//   bus_rdata, bus_ready            bus response
//   grant                           one-hot owner (bit0 CPU, bit1 DMA)
//   timeout_err                     sticky abort flag
module mio_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state;
  logic   last;          // last master served: 0 = CPU, 1 = DMA
  logic   cpu_win_c;
  logic   dma_win_c;
  logic   xfer_abort_c;  // XFER ends without bus_ready (timeout)
  logic   xfer_end_c;

  // Out-of-range TIMEOUT_CYCLES leaves a marker block in the hierarchy
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
  end

  // Round-robin: on a tie the master that was not served last wins
  assign cpu_win_c = cpu_req && (!dma_req || last);
  assign dma_win_c = dma_req && !cpu_win_c;

  assign xfer_end_c = (state == XFER) && (bus_ready || xfer_abort_c);

`ifdef MIO_ARB_TIMEOUT_EN
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  assign xfer_abort_c = (state == XFER) && !bus_ready && (wait_cnt == TO_LAST);

  // Wait counter: cleared while idle so it starts at zero on XFER entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != XFER) begin
      wait_cnt <= '0;
    end else if (!bus_ready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Sticky abort flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (xfer_abort_c) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign xfer_abort_c = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // Arbitration FSM with registered bus and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      grant     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_win_c || dma_win_c) begin
            state     <= XFER;
            grant     <= {dma_win_c, cpu_win_c};
            last      <= dma_win_c;
            bus_req   <= 1'b1;
            bus_we    <= dma_win_c ? dma_we    : cpu_we;
            bus_addr  <= dma_win_c ? dma_addr  : cpu_addr;
            bus_wdata <= dma_win_c ? dma_wdata : cpu_wdata;
          end
        end
        XFER: begin
          if (xfer_end_c) begin
            state     <= RESP;
            bus_req   <= 1'b0;
            cpu_ready <= grant[0];
            dma_ready <= grant[1];
            // A timed-out transfer returns zero data
            if (grant[1]) begin
              dma_rdata <= bus_ready ? bus_rdata : DW'(0);
            end else begin
              cpu_rdata <= bus_ready ? bus_rdata : DW'(0);
            end
          end
        end
        RESP: begin
          state <= IDLE;
          grant <= 2'b00;
        end
        default: begin
          state   <= IDLE;
          grant   <= 2'b00;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Testbench for mio_bus_arbiter: directed stimulus, a bus responder model and
// a scoreboard of expected ready responses checked by an independent monitor.
module tb_mio_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ready, dma_ready;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        master;  // 0 = CPU, 1 = DMA
    logic [31:0] rdata;
    logic        terr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Bus responder controls
  int          bus_delay  = 0;
  bit          bus_hold   = 0;
  bit          use_fixed  = 0;
  logic [31:0] fixed_data = '0;
  int          wait_cnt   = 0;

  mio_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] bus_data(input logic [31:0] addr);
    return {addr[15:0], 16'hBEEF};
  endfunction

  // Bus slave: ready after bus_delay low cycles of an active request
  always @(negedge clk) begin
    if (reset || !bus_req) begin
      bus_ready = 1'b0;
      wait_cnt  = 0;
    end else begin
      bus_rdata = use_fixed ? fixed_data : bus_data(bus_addr);
      bus_ready = (!bus_hold && wait_cnt >= bus_delay);
      wait_cnt  = wait_cnt + 1;
    end
  end

  // Monitor: every ready pulse must match the next expected response
  always @(negedge clk) begin
    if (!reset && (cpu_ready || dma_ready)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {dma_ready, cpu_ready}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check("ready_owner", {dma_ready, cpu_ready}, mon_e.master ? 2'b10 : 2'b01);
        check("resp_grant", grant, mon_e.master ? 2'b10 : 2'b01);
        check("resp_rdata", mon_e.master ? dma_rdata : cpu_rdata, mon_e.rdata);
        check("resp_timeout_err", timeout_err, mon_e.terr);
      end
    end
  end

  task automatic push(input logic master, input logic [31:0] rdata, input logic terr);
    exp_t e;
    e.master = master;
    e.rdata  = rdata;
    e.terr   = terr;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    bus_rdata = '0; bus_ready = 0;

    // Reset values
    tick(2);
    check("rst_grant", grant, 2'b00);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_ready", {dma_ready, cpu_ready}, 2'b00);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_dma_rdata", dma_rdata, 32'h0);
    check("rst_timeout_err", timeout_err, 1'b0);
    reset = 1'b0;
    tick(1);

    // CPU read, bus ready in the first XFER cycle
    use_fixed = 1; fixed_data = 32'h1234_5678;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040;
    push(1'b0, 32'h1234_5678, 1'b0);
    tick(1);
    check("t1_bus_req", bus_req, 1'b1);
    check("t1_bus_addr", bus_addr, 32'h40);
    check("t1_grant", grant, 2'b01);
    check("t1_bus_we", bus_we, 1'b0);
    tick(1);
    check("t1_cpu_ready_latency", cpu_ready, 1'b1);
    cpu_req = 0;
    tick(1);
    check("t1_ready_single", cpu_ready, 1'b0);
    check("t1_rdata_held", cpu_rdata, 32'h1234_5678);
    check("t1_dma_rdata", dma_rdata, 32'h0);
    check("t1_idle_grant", grant, 2'b00);
    use_fixed = 0;

    // Both masters requesting after reset: CPU, DMA, CPU, DMA
    pulse_reset();
    cpu_addr = 32'h0000_0100; dma_addr = 32'h0000_0200;
    cpu_req = 1; dma_req = 1;
    push(1'b0, 32'h0100_BEEF, 1'b0);
    push(1'b1, 32'h0200_BEEF, 1'b0);
    push(1'b0, 32'h0100_BEEF, 1'b0);
    push(1'b1, 32'h0200_BEEF, 1'b0);
    tick(1);
    check("t2_first_grant", grant, 2'b01);
    tick(3);
    check("t2_second_grant", grant, 2'b10);
    tick(7);
    cpu_req = 0; dma_req = 0;
    tick(3);
    check("t2_all_responses", exp_q.size(), 0);

    // DMA write on a slow bus: request must stay stable across 6 XFER cycles
    bus_delay = 5;
    dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0300; dma_wdata = 32'hCAFE_F00D;
    push(1'b1, 32'h0300_BEEF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("t3_xfer_stable", {bus_req, bus_we, bus_addr, bus_wdata},
            {1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D});
    end
    tick(1);
    check("t3_dma_ready", dma_ready, 1'b1);
    check("t3_resp_bus_req", bus_req, 1'b0);
    dma_req = 0; dma_we = 0;
    tick(2);
    bus_delay = 0;

    // Reset during XFER, then the next tie goes to the CPU
    bus_hold = 1;
    cpu_req = 1; cpu_addr = 32'h0000_0400;
    tick(1);
    check("t4_in_xfer", bus_req, 1'b1);
    reset = 1'b1;
    #1;
    check("t4_rst_outputs", {bus_req, grant, cpu_ready, dma_ready, timeout_err}, 6'b0);
    cpu_req = 0;
    tick(1);
    reset = 1'b0;
    bus_hold = 0;
    cpu_addr = 32'h0000_0410; dma_addr = 32'h0000_0420; dma_we = 0;
    cpu_req = 1; dma_req = 1;
    push(1'b0, 32'h0410_BEEF, 1'b0);
    push(1'b1, 32'h0420_BEEF, 1'b0);
    tick(1);
    check("t4_tie_cpu", grant, 2'b01);
    tick(1);
    cpu_req = 0;
    tick(3);
    dma_req = 0;
    tick(2);

    // CPU drops req in the second XFER cycle: completes once, no re-grant
    bus_delay = 3;
    cpu_req = 1; cpu_addr = 32'h0000_0500;
    push(1'b0, 32'h0500_BEEF, 1'b0);
    tick(2);
    cpu_req = 0;
    tick(3);
    check("t5_cpu_ready", cpu_ready, 1'b1);
    tick(1);
    check("t5_no_regrant_a", {bus_req, grant}, 3'b000);
    tick(1);
    check("t5_no_regrant_b", {bus_req, grant}, 3'b000);
    bus_delay = 0;

    // Bus never responds
    bus_hold = 1;
    cpu_req = 1; cpu_addr = 32'h0000_0600;
`ifdef MIO_ARB_TIMEOUT_EN
    push(1'b0, 32'h0, 1'b1);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick(1);
      if (cpu_ready) n = i;
    end
    check("t6_timeout_pulse_cycle", n, 5);
    cpu_req = 0;
    bus_hold = 0;
    tick(3);
    check("t6_timeout_sticky", timeout_err, 1'b1);
    check("t6_timeout_rdata", cpu_rdata, 32'h0);
    dma_req = 1; dma_addr = 32'h0000_0700;
    push(1'b1, 32'h0700_BEEF, 1'b1);
    tick(2);
    dma_req = 0;
    tick(2);
    check("t6_sticky_after_xfer", timeout_err, 1'b1);
`else
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (cpu_ready) pulses++;
    end
    check("t6_no_pulse_100", pulses, 0);
    check("t6_still_waiting", {bus_req, grant}, 3'b101);
    check("t6_timeout_err_tied", timeout_err, 1'b0);
    cpu_req = 0;
    pulse_reset();
    bus_hold = 0;
`endif

    tick(4);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
# mio_bus_arbiter

Two-master arbiter for the single memory/IO bus shared by the multi-cycle CPU and a secondary master (DMA/display fetch engine). Grants one master at a time with round-robin priority, drives the registered bus request, waits for the bus ready handshake, and returns read data with a one-cycle ready pulse. The CPU controller stalls on `cpu_ready` exactly as it does on a memory-ready signal today.

## Interface
- `TIMEOUT_CYCLES`, default 16: cycles in XFER without `bus_ready` before abort. Used only with the timeout macro; range 2..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `cpu_req`  in  1  CPU request; held with address/data until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  CPU byte address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  read data; valid while `cpu_ready` = 1, held afterwards.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`: same as the CPU inputs, for the DMA master.
- `dma_ready`, `dma_rdata`: same as the CPU outputs, for the DMA master.
- `bus_req`  out  1  bus transaction active.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  32  bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_rdata`  in  32  bus read data; sampled when `bus_ready` = 1.
- `bus_ready`  in  1  bus completion; may be held high.
- `grant`  out  2  one-hot owner: bit 0 = CPU, bit 1 = DMA; `2'b00` when idle.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- States: IDLE=2'b00, XFER=2'b01, RESP=2'b10. 2'b11 is illegal and goes to IDLE.
- Round-robin bit `last` records the last master served: 0 = CPU, 1 = DMA.
- IDLE, arbitration:
  - If only one master has `req` = 1, that master wins.
  - If both have `req` = 1, the master not equal to `last` wins.
  - On a win: latch that master's we/addr/wdata into the bus registers, set `grant`, update `last`, go to XFER.
- XFER:
  - `bus_req` = 1.
  - bus_we/addr/wdata stay stable at the latched values.
  - On `bus_ready` = 1: capture `bus_rdata` into the owner's rdata register (captured for writes too), then go to RESP.
- RESP:
  - `bus_req` = 0; the owner's ready = 1 for exactly this cycle; `grant` is still held.
  - Then go to IDLE and clear `grant`.
- Requests are not re-evaluated during XFER or RESP. A master dropping `req` mid-transaction does not abort it.
- The non-owner's ready stays 0. Its rdata register is unchanged.
- Reset values:
  - state = IDLE, `last` = 1 (CPU wins the first tie).
  - `grant` = 0, `bus_req` = 0, `bus_we` = 0, `bus_addr` = 0, `bus_wdata` = 0.
  - Both ready outputs = 0, both rdata outputs = 0, `timeout_err` = 0.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. No ready pulse is issued for the aborted transaction.

## Timing
- Request seen in IDLE at edge N → `bus_req` high in the cycle after N.
- `bus_ready` sampled high at edge M → requester ready high in the cycle after M. IDLE follows at edge M+1.
- Minimum latency: 3 cycles from request to the cycle after the ready pulse, when `bus_ready` is high in the first XFER cycle.
- Back-to-back requests from one master: a new transaction every 3 cycles minimum.
- With both masters requesting continuously, grants alternate CPU, DMA, CPU, …
- A master that keeps `req` high through its ready cycle is re-arbitrated in the next IDLE cycle as a new request.

## Configuration
- `MIO_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on XFER entry and increments each XFER cycle with `bus_ready` = 0.
  - When it reaches `TIMEOUT_CYCLES - 1` with `bus_ready` still 0: the owner's rdata = 32'h0000_0000, go to RESP, the owner's ready pulses normally, and `timeout_err` sets and stays 1 until reset.
- `MIO_ARB_TIMEOUT_EN` not defined: XFER waits indefinitely, `timeout_err` is tied 0, no counter is built, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- CPU read only: `cpu_req` = 1, addr 0x0000_0040, bus returns 0x1234_5678 with `bus_ready` in the first XFER cycle → `bus_addr` = 0x40, `grant` = 01, `cpu_ready` one-cycle pulse 2 cycles after the request, `cpu_rdata` = 0x1234_5678, `dma_ready` stays 0.
- Simultaneous requests after reset: CPU and DMA both held high → grant sequence 01, 10, 01, 10. Each ready pulses once per own grant.
- DMA write with a slow bus: `dma_we` = 1, wdata 0xCAFE_F00D, `bus_ready` delayed 5 cycles → bus_we/addr/wdata stable for all 6 XFER cycles, then one `dma_ready` pulse.
- Reset asserted in XFER → `bus_req`, `grant`, ready and `timeout_err` all 0 immediately. Next tie goes to the CPU.
- With `MIO_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES = 4, `bus_ready` held 0 → `cpu_ready` pulses after 4 XFER cycles, `cpu_rdata` = 0, `timeout_err` = 1 and sticky. Without the macro, the bench sees no pulse within 100 cycles.
- `cpu_req` dropped in the second XFER cycle → the transaction still completes, `cpu_ready` pulses once, and there is no re-grant to the CPU.
